ex_muldiv_unit: RTL
===================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, fed directly by the ID/EX pipeline register outputs. It detects M-extension instructions on the EX-stage opcode/funct fields and computes the result over multiple cycles. While computing, it holds the front of the pipeline with a busy stall, then presents a one-cycle result for the EX/MEM path.

## Interface
- CORE, 0, core index, carried for instance identification only
- DATA_WIDTH, 32, operand/result width; counter width is clog2(DATA_WIDTH)+1
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- ex_opcode  input  7  EX-stage opcode
- ex_funct3  input  3  selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (0..7)
- ex_funct7  input  7  must be 7'b0000001 for M-extension
- ex_rs1_data  input  DATA_WIDTH  operand A (multiplicand/dividend)
- ex_rs2_data  input  DATA_WIDTH  operand B (multiplier/divisor)
- ex_rd  input  5  destination register
- flush  input  1  branch/jump squash of the EX-stage instruction
- muldiv_busy  output  1  stall request to PC, IF/ID and ID/EX registers
- muldiv_valid  output  1  one-cycle result strobe
- muldiv_result  output  DATA_WIDTH  result, held until next valid
- muldiv_rd  output  5  destination of muldiv_result

## Operation
- start = (ex_opcode==7'b0110011) && (ex_funct7==7'b0000001) && !flush, honoured only in IDLE.
- States:
  - IDLE: on start, latch funct3, rd, and operand magnitudes plus result sign.
    - Go DONE directly for special divides.
    - Otherwise go CALC, count=0.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add into a 2*DATA_WIDTH product.
    - Divide: restoring shift-subtract.
    - count increments each cycle; go DONE when count==DATA_WIDTH-1.
  - DONE: apply sign correction, drive muldiv_valid=1, update muldiv_result/muldiv_rd, go IDLE. Start is never accepted in DONE.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - DIV/REM: signed; quotient sign = sign A xor sign B; remainder sign = sign A.
- Result select:
  - MUL: low DATA_WIDTH of the product.
  - MULH*: high DATA_WIDTH of the product; negation is 2*DATA_WIDTH two's complement.
- Special cases (no CALC):
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Signed overflow (rs1 = -2^(DATA_WIDTH-1), rs2 = -1): quotient = rs1, remainder = 0.
- flush or reset: state←IDLE, count←0. The in-flight operation is discarded and no valid is produced.

## Timing
- Reset values: muldiv_busy=0, muldiv_valid=0, muldiv_result=0, muldiv_rd=0, state=IDLE.
- muldiv_busy = (state==IDLE && start) || state==CALC. It is combinational from the EX inputs so the ID/EX register holds on the accept cycle. It is low in DONE, so the pipeline advances on the same edge the result is consumed.
- Latency, with the accept edge as cycle 0:
  - Normal op: valid in cycle DATA_WIDTH+1 (33 for 32-bit); busy high for cycles 0..DATA_WIDTH.
  - Special divide: valid in cycle 1; busy high for cycle 0 only.
- Back-to-back M ops: the second is accepted in the IDLE cycle right after DONE. No bubble beyond the mandatory DONE cycle.
- Non-M instructions in IDLE: busy=0, valid=0, result unchanged.
- flush during CALC: IDLE on the next edge. busy drops on the next cycle.
- flush in the same cycle as an IDLE start: not accepted.
- reset mid-operation behaves identically to flush, and also clears the outputs.

## Structure
- Shared package rv_muldiv_pkg:
  - OPCODE_OP=7'b0110011, FUNCT7_MULDIV=7'b0000001.
  - funct3 localparams F3_MUL..F3_REMU.
  - State encoding IDLE/CALC/DONE.
- One sub-module: muldiv_datapath, containing the product/remainder shift registers, the adder/subtractor, and sign correction. The top holds the FSM, counter and handshake.

## Test plan
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD) → valid at cycle 33, result 0xFFFFFFEB, rd echoed; busy high cycles 0–32.
- MULH/MULHU/MULHSU with 0x80000000 × 0xFFFFFFFF → 0x00000000 / 0x7FFFFFFF / 0x80000000.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV x/0 with x=0x1234 → 0xFFFFFFFF at cycle 1; REM → 0x1234. DIV 0x80000000/-1 → 0x80000000; REM → 0.
- flush at cycle 10 of a DIV → busy low from cycle 11, no valid ever; a following MUL 3×4 returns 12 after 33 cycles.
- reset asserted at cycle 5 of a MUL → all outputs 0 the next cycle. Back-to-back MUL then DIV → two valids 34 cycles apart.

Source files
------------

// File: rtl/rv_muldiv_pkg.sv
// Shared constants, state encoding and operation-class helpers for the RV32M multiply/divide unit.
package rv_muldiv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] funct3);
        return funct3[2] && funct3[1];
    endfunction

    function automatic logic is_signed_div(input logic [2:0] funct3);
        return (funct3 == F3_DIV) || (funct3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage instruction fields in, stall/result handshake out, for the multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic [6:0]            ex_opcode;
    logic [2:0]            ex_funct3;
    logic [6:0]            ex_funct7;
    logic [DATA_WIDTH-1:0] ex_rs1_data;
    logic [DATA_WIDTH-1:0] ex_rs2_data;
    logic [4:0]            ex_rd;
    logic                  flush;
    logic                  muldiv_busy;
    logic                  muldiv_valid;
    logic [DATA_WIDTH-1:0] muldiv_result;
    logic [4:0]            muldiv_rd;

    modport master (
        output ex_opcode, ex_funct3, ex_funct7, ex_rs1_data, ex_rs2_data, ex_rd, flush,
        input  muldiv_busy, muldiv_valid, muldiv_result, muldiv_rd
    );

    modport slave (
        input  ex_opcode, ex_funct3, ex_funct7, ex_rs1_data, ex_rs2_data, ex_rd, flush,
        output muldiv_busy, muldiv_valid, muldiv_result, muldiv_rd
    );
endinterface

// File: rtl/ex_muldiv_unit_datapath.sv
// Sign/magnitude operand capture, radix-2 shift-add multiply / restoring divide, and final sign fix-up.
module muldiv_datapath
    import rv_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  special,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic         a_signed, b_signed, a_neg, b_neg, res_neg;
    logic         div_zero, div_ovf;
    logic [W-1:0] a_mag, b_mag;

    logic [2:0]   op_q;
    logic         neg_q;
    logic [W-1:0] opnd_q, hi_q, lo_q;

    logic [W:0]     add_sum;
    logic [W:0]     shifted;
    logic [W-1:0]   sub_diff;
    logic           sub_ge;
    logic [2*W-1:0] prod_c;
    logic [W-1:0]   quo_c, rem_c;

    always_comb begin
        a_signed = !((funct3 == F3_MULHU) || (funct3 == F3_DIVU) || (funct3 == F3_REMU));
        b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_signed && rs1_data[W-1];
        b_neg    = b_signed && rs2_data[W-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div_zero = is_div(funct3) && (rs2_data == '0);
        div_ovf  = is_signed_div(funct3) && (rs1_data == MOST_NEG) && (rs2_data == '1);
        special  = div_zero || div_ovf;
        // remainder follows the dividend; everything else is sign(A) xor sign(B)
        res_neg  = is_rem(funct3) ? a_neg : (a_neg ^ b_neg);
    end

    always_comb begin
        add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted  = {hi_q, lo_q[W-1]};
        sub_ge   = shifted >= {1'b0, opnd_q};
        sub_diff = shifted[W-1:0] - opnd_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= F3_MUL;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (load) begin
            op_q   <= funct3;
            neg_q  <= res_neg && !special;
            opnd_q <= is_div(funct3) ? b_mag : a_mag;
            // special divides preload the final quotient (lo) and remainder (hi)
            if (div_zero) begin
                hi_q <= rs1_data;
                lo_q <= '1;
            end else if (div_ovf) begin
                hi_q <= '0;
                lo_q <= rs1_data;
            end else begin
                hi_q <= '0;
                lo_q <= is_div(funct3) ? a_mag : b_mag;
            end
        end else if (step) begin
            if (is_div(op_q)) begin
                hi_q <= sub_ge ? sub_diff : shifted[W-1:0];
                lo_q <= {lo_q[W-2:0], sub_ge};
            end else begin
                hi_q <= add_sum[W:1];
                lo_q <= {add_sum[0], lo_q[W-1:1]};
            end
        end
    end

    always_comb begin
        prod_c = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_c  = neg_q ? -lo_q : lo_q;
        rem_c  = neg_q ? -hi_q : hi_q;
        case (op_q)
            F3_MUL:                        result = prod_c[W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_c[2*W-1:W];
            F3_DIV, F3_DIVU:               result = quo_c;
            default:                       result = rem_c;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative RV32M unit: accept FSM, step counter and stall/result handshake.
//   state | meaning
//   IDLE  | waiting; an M instruction in EX is accepted combinationally (busy) and latched
//   CALC  | one multiply/divide step per cycle, DATA_WIDTH cycles
//   DONE  | result strobed for one cycle, pipeline released
module ex_muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    ex_muldiv_unit_if.slave mdu
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    if (CORE < 0) begin : g_core_check
        $error("CORE index must be non-negative");
    end

    muldiv_state_e         state_q, state_nxt;
    logic [CW-1:0]         count_q;
    logic                  start, accept, dp_special;
    logic [4:0]            rd_lat_q, rd_q;
    logic [DATA_WIDTH-1:0] result_q, dp_result;

    assign start  = (mdu.ex_opcode == OPCODE_OP) && (mdu.ex_funct7 == FUNCT7_MULDIV) && !mdu.flush;
    assign accept = (state_q == IDLE) && start;

    muldiv_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .step     (state_q == CALC),
        .funct3   (mdu.ex_funct3),
        .rs1_data (mdu.ex_rs1_data),
        .rs2_data (mdu.ex_rs2_data),
        .special  (dp_special),
        .result   (dp_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_nxt;
            count_q <= ((state_q == CALC) && (state_nxt == CALC)) ? count_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start) state_nxt = dp_special ? DONE : CALC;
            CALC: begin
                if (mdu.flush)                               state_nxt = IDLE;
                else if (count_q == CW'(DATA_WIDTH - 1))     state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_lat_q <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            if (accept) rd_lat_q <= mdu.ex_rd;
            if (state_q == DONE) begin
                rd_q     <= rd_lat_q;
                result_q <= dp_result;
            end
        end
    end

    // result is live during DONE so valid lands on the same cycle; held copy afterwards
    always_comb begin
        mdu.muldiv_busy   = accept || (state_q == CALC);
        mdu.muldiv_valid  = (state_q == DONE);
        mdu.muldiv_result = (state_q == DONE) ? dp_result : result_q;
        mdu.muldiv_rd     = (state_q == DONE) ? rd_lat_q : rd_q;
    end

endmodule
